sram_client_port: RTL and testbench

- Sequential requester-side engine for one SRAM client slot, such as the bus, node, sym or mc slot, of the shared SRAM arbiter/mux.
- Accepts a single-cycle burst command (read or write, start address, beat count).
- Waits until the arbiter state grants its slot, then drives the slot's addr/read/write/data lines beat by beat.
- For reads, captures the SRAM read data after a fixed latency and streams it back with a valid strobe.

---
 rtl/sram_pkg.sv | 25 ++
 rtl/sram_beat_counter.sv | 34 +++
 rtl/sram_client_port.sv | 153 +++++++++++++++
 tb/tb_sram_client_port.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter/mux and its client-side engines.
package sram_pkg;

   localparam int SRAM_ADDR_W = 16;
   localparam int SRAM_DATA_W = 8;

   // Arbiter state codes; a client slot is granted when the arbiter sits in its code.
   typedef enum logic [2:0] {
      ARB_IDLE = 3'b000,
      ARB_BUS  = 3'b001,
      ARB_NODE = 3'b010,
      ARB_SYM  = 3'b011,
      ARB_MC   = 3'b100
   } arb_state_t;

   // Requester-side burst engine states.
   typedef enum logic [2:0] {
      CL_IDLE,
      CL_WAIT_GRANT,
      CL_WRITE,
      CL_READ,
      CL_DONE
   } client_fsm_t;

endpackage

// File: rtl/sram_beat_counter.sv
// Burst bookkeeping: current address (wraps modulo 2^ADDR_W) and remaining-beat down-counter.
module sram_beat_counter #(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   output logic [ADDR_W-1:0] addr,
   output logic [LEN_W-1:0]  beats,
   output logic              last
);

   // Load on command accept, otherwise advance one beat per completed transfer.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         addr  <= '0;
         beats <= '0;
      end else if (load) begin
         addr  <= load_addr;
         beats <= load_len;
      end else if (step) begin
         addr  <= addr + 1'b1;
         beats <= beats - 1'b1;
      end
   end

   // beats holds "remaining minus one", so zero marks the final beat.
   assign last = (beats == '0);

endmodule

// File: rtl/sram_client_port.sv
// Requester engine for one SRAM arbiter client slot: accepts a burst command,
// waits for the slot grant, issues beats, and returns read data with a strobe.
module sram_client_port
   import sram_pkg::*;
#(
   parameter int          ADDR_W    = SRAM_ADDR_W,
   parameter int          DATA_W    = SRAM_DATA_W,
   parameter logic [2:0]  CLIENT_ID = 3'b001,
   parameter int          RD_LAT    = 1,
   parameter int          LEN_W     = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [2:0]        grant_state,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic [DATA_W-1:0] wdata,
   output logic              wdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] LAT_MAX = 2'(RD_LAT);

   client_fsm_t       state, state_nxt;
   logic              we_q;
   logic [1:0]        lat_q;
   logic              granted;
   logic              load, step, capture, lat_clr, lat_inc;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  beats_q;
   logic              last_beat;

   assign granted = (grant_state == CLIENT_ID);

   sram_beat_counter #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_beat_counter (
      .clk       (clk),
      .n_rst     (n_rst),
      .load      (load),
      .step      (step),
      .load_addr (start_addr),
      .load_len  (burst_len),
      .addr      (addr_q),
      .beats     (beats_q),
      .last      (last_beat)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= CL_IDLE;
      else        state <= state_nxt;
   end

   // Next state and strobes; mem_read/mem_write follow the grant compare combinationally
   // so a lost grant drops them in the same cycle and no beat completes.
   always_comb begin
      state_nxt   = state;
      load        = 1'b0;
      step        = 1'b0;
      capture     = 1'b0;
      lat_clr     = 1'b0;
      lat_inc     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      wdata_ready = 1'b0;
      done        = 1'b0;
      case (state)
         CL_IDLE: begin
            if (req) begin
               load      = 1'b1;
               state_nxt = CL_WAIT_GRANT;
            end
         end
         CL_WAIT_GRANT: begin
            lat_clr = 1'b1;
            if (granted) state_nxt = we_q ? CL_WRITE : CL_READ;
         end
         CL_WRITE: begin
            if (granted) begin
               mem_write   = 1'b1;
               wdata_ready = 1'b1;
               step        = 1'b1;
               if (last_beat) state_nxt = CL_DONE;
            end else begin
               state_nxt = CL_WAIT_GRANT;
            end
         end
         CL_READ: begin
            if (granted) begin
               mem_read = 1'b1;
               if (lat_q == LAT_MAX) begin
                  capture = 1'b1;
                  step    = 1'b1;
                  lat_clr = 1'b1;
                  if (last_beat) state_nxt = CL_DONE;
               end else begin
                  lat_inc = 1'b1;
               end
            end else begin
               // Partial read beat is abandoned; its latency count restarts on regrant.
               lat_clr   = 1'b1;
               state_nxt = CL_WAIT_GRANT;
            end
         end
         CL_DONE: begin
            done      = 1'b1;
            state_nxt = CL_IDLE;
         end
         default: state_nxt = CL_IDLE;
      endcase
   end

   // Latch burst direction with the command; ignored while busy since load only fires in IDLE.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)    we_q <= 1'b0;
      else if (load) we_q <= we;
   end

   // Read latency counter, 0..RD_LAT per beat.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)       lat_q <= '0;
      else if (lat_clr) lat_q <= '0;
      else if (lat_inc) lat_q <= lat_q + 1'b1;
   end

   // Capture read data at the end of the beat; the strobe qualifies it the following cycle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else begin
         rdata_valid <= capture;
         if (capture) rdata <= mem_rdata;
      end
   end

   assign busy      = (state != CL_IDLE);
   assign mem_addr  = addr_q;
   assign mem_wdata = mem_write ? wdata : '0;

endmodule

// File: tb/tb_sram_client_port.sv
// Directed bench for sram_client_port with a one-cycle-latency SRAM model and a
// byte source that advances on wdata_ready.
module tb_sram_client_port;

   localparam logic [2:0] CID = 3'b001;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic [2:0]  grant_state = 3'b000;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [15:0] start_addr = '0;
   logic [3:0]  burst_len = '0;
   logic [7:0]  wdata;
   logic        wdata_ready;
   logic [7:0]  rdata;
   logic        rdata_valid;
   logic        busy;
   logic        done;
   logic [15:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;

   always #5 clk = ~clk;

   sram_client_port #(
      .ADDR_W(16), .DATA_W(8), .CLIENT_ID(CID), .RD_LAT(1), .LEN_W(4)
   ) dut (
      .clk(clk), .n_rst(n_rst), .grant_state(grant_state), .req(req), .we(we),
      .start_addr(start_addr), .burst_len(burst_len), .wdata(wdata),
      .wdata_ready(wdata_ready), .rdata(rdata), .rdata_valid(rdata_valid),
      .busy(busy), .done(done), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int req_cyc = 0;

   // SRAM model: registered write, read data one cycle after mem_read.
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr];
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Write byte source: base + index, index steps on wdata_ready.
   logic [7:0] src_base = '0;
   logic [7:0] src_idx = '0;
   int clr_req = 0;
   int src_seen = 0;
   assign wdata = src_base + src_idx;
   always @(posedge clk) begin
      if (clr_req != src_seen) begin
         src_seen <= clr_req;
         src_idx  <= '0;
      end else if (wdata_ready) begin
         src_idx <= src_idx + 8'd1;
      end
   end

   // Event log, sampled on the falling edge.
   int mon_seen = 0;
   int wr_cnt, rd_cnt, rv_cnt, rdy_cnt, done_cnt, bad_cnt;
   int first_wr_cyc, last_wr_cyc, last_rv_cyc, done_cyc;
   logic [15:0] wr_addr [32];
   logic [7:0]  wr_data [32];
   logic [15:0] rd_addr [32];
   logic [7:0]  rv_data [32];
   always @(negedge clk) begin
      if (clr_req != mon_seen) begin
         mon_seen = clr_req;
         wr_cnt = 0; rd_cnt = 0; rv_cnt = 0; rdy_cnt = 0; done_cnt = 0; bad_cnt = 0;
      end
      if ((mem_write || mem_read) && grant_state != CID) bad_cnt++;
      if (mem_write) begin
         if (wr_cnt < 32) begin
            wr_addr[wr_cnt] = mem_addr;
            wr_data[wr_cnt] = mem_wdata;
         end
         if (wr_cnt == 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         wr_cnt++;
      end
      if (mem_read) begin
         if (rd_cnt < 32) rd_addr[rd_cnt] = mem_addr;
         rd_cnt++;
      end
      if (rdata_valid) begin
         if (rv_cnt < 32) rv_data[rv_cnt] = rdata;
         last_rv_cyc = cyc;
         rv_cnt++;
      end
      if (wdata_ready) rdy_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [15:0] a, input logic [3:0] l);
      clr_req++;
      req = 1'b1; we = w; start_addr = a; burst_len = l;
      req_cyc = cyc;
      tick();
      req = 1'b0;
   endtask

   // Bounded wait for done, then confirm exactly one pulse.
   task automatic run_until_done(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 100) begin
         tick();
         n++;
      end
      tick();
      tick();
      chk({tag, "_done"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_rw", 32'({mem_read, mem_write, wdata_ready, rdata_valid}), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      n_rst = 1'b1;
      tick();

      // Write burst, grant held
      grant_state = CID;
      src_base = 8'hA0;
      issue(1'b1, 16'h0010, 4'd3);
      chk("w_busy", 32'(busy), 32'd1);
      run_until_done("w");
      chk("w_cnt", 32'(wr_cnt), 32'd4);
      chk("w_lat", 32'(first_wr_cyc - req_cyc), 32'd2);
      chk("w_consec", 32'(last_wr_cyc - first_wr_cyc), 32'd3);
      chk("w_addr0", 32'(wr_addr[0]), 32'h10);
      chk("w_addr3", 32'(wr_addr[3]), 32'h13);
      chk("w_rdy", 32'(rdy_cnt), 32'd4);
      chk("w_donecyc", 32'(done_cyc - last_wr_cyc), 32'd1);
      chk("w_mem", {mem[16'h10], mem[16'h11], mem[16'h12], mem[16'h13]}, 32'hA0A1A2A3);
      chk("w_idle", 32'(busy), 32'd0);

      // Read burst back
      issue(1'b0, 16'h0010, 4'd3);
      run_until_done("r");
      chk("r_rdcyc", 32'(rd_cnt), 32'd8);
      chk("r_addr", {rd_addr[0], rd_addr[7]}, 32'h0010_0013);
      chk("r_strobes", 32'(rv_cnt), 32'd4);
      chk("r_data", {rv_data[0], rv_data[1], rv_data[2], rv_data[3]}, 32'hA0A1A2A3);
      chk("r_donecyc", 32'(done_cyc), 32'(last_rv_cyc));
      chk("r_nowr", 32'(wr_cnt), 32'd0);

      // Grant withheld, then dropped after beat 2
      grant_state = 3'b000;
      src_base = 8'hB0;
      issue(1'b1, 16'h0010, 4'd3);
      repeat (4) tick();
      chk("g_none", 32'(wr_cnt + rd_cnt), 32'd0);
      grant_state = CID;
      begin
         int n = 0;
         while (wr_cnt < 2 && n < 50) begin
            tick();
            n++;
         end
      end
      grant_state = 3'b000;
      tick();
      tick();
      chk("g_held", 32'(wr_cnt), 32'd2);
      grant_state = CID;
      run_until_done("g");
      chk("g_lat", 32'(first_wr_cyc - req_cyc), 32'd6);
      chk("g_cnt", 32'(wr_cnt), 32'd4);
      chk("g_resume", 32'(wr_addr[2]), 32'h12);
      chk("g_rdy", 32'(rdy_cnt), 32'd4);
      chk("g_bad", 32'(bad_cnt), 32'd0);
      chk("g_mem", {mem[16'h10], mem[16'h11], mem[16'h12], mem[16'h13]}, 32'hB0B1B2B3);

      // Address wrap: write then read FFFE, FFFF, 0000
      src_base = 8'h50;
      issue(1'b1, 16'hFFFE, 4'd2);
      run_until_done("ww");
      chk("ww_addr", {wr_addr[1], wr_addr[2]}, 32'hFFFF_0000);
      issue(1'b0, 16'hFFFE, 4'd2);
      run_until_done("wr");
      chk("wr_addr0", 32'(rd_addr[0]), 32'hFFFE);
      chk("wr_addr", {rd_addr[2], rd_addr[4]}, 32'hFFFF_0000);
      chk("wr_data", {8'h00, rv_data[0], rv_data[1], rv_data[2]}, 32'h00505152);

      // Reset during beat 2 of an 8-beat write
      src_base = 8'hC0;
      issue(1'b1, 16'h0040, 4'd7);
      begin
         int n = 0;
         while (wr_cnt < 1 && n < 50) begin
            tick();
            n++;
         end
      end
      chk("x_pre", 32'(mem_write), 32'd1);
      n_rst = 1'b0;
      #1;
      chk("x_out", 32'({busy, mem_write, mem_read, wdata_ready, done, rdata_valid}), 32'd0);
      chk("x_bus", {mem_addr, mem_wdata, rdata}, 32'd0);
      repeat (3) tick();
      n_rst = 1'b1;
      repeat (3) tick();
      chk("x_nodone", 32'(done_cnt), 32'd0);
      chk("x_cnt", 32'(wr_cnt), 32'd1);
      chk("x_idle", 32'(busy), 32'd0);

      // Req while busy is ignored
      grant_state = 3'b000;
      src_base = 8'hD0;
      issue(1'b1, 16'h0080, 4'd1);
      tick();
      req = 1'b1; we = 1'b0; start_addr = 16'h0090; burst_len = 4'd5;
      tick();
      req = 1'b0;
      chk("i_busy", 32'(busy), 32'd1);
      grant_state = CID;
      run_until_done("i");
      chk("i_cnt", 32'(wr_cnt + (rd_cnt << 8)), 32'd2);
      chk("i_addr", {wr_addr[0], wr_addr[1]}, 32'h0080_0081);

      // Next idle req starts cleanly
      issue(1'b0, 16'h0080, 4'd1);
      run_until_done("n");
      chk("n_addr", 32'(rd_addr[0]), 32'h0080);
      chk("n_data", {16'h0, rv_data[0], rv_data[1]}, 32'h0000D0D1);
      chk("n_strobes", 32'(rv_cnt), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
